writeback_buffer: RTL and testbench
===================================

Name: writeback_buffer

Overview:
- Sits directly downstream of the L1 arbiter, between the arbiter's L2-side port and physical memory.
- Absorbs dirty-line writebacks from either L1 into a small FIFO, so the arbiter gets a write response in 2 cycles.
- Drains buffered lines to pmem in the background.
- Services arbiter reads, either from a buffered line on an address match or by forwarding to pmem.

Parameters:
DEPTH, 2, number of 128-bit line entries (power of 2, >=1)
ADDR_W, 16, byte address width
LINE_W, 128, line width in bits (offset = 4 bits)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ev_read  in  1  arbiter read request, held until ev_resp
ev_write  in  1  arbiter writeback request, held until ev_resp
ev_addr  in  16  arbiter line address (bits [3:0] ignored)
ev_wdata  in  128  writeback line data
ev_rdata  out  128  read line data, valid in ev_resp cycle
ev_resp  out  1  one-cycle completion pulse to arbiter
pmem_read  out  1  pmem read request
pmem_write  out  1  pmem write request
pmem_addr  out  16  pmem line address, bits [3:0] = 0
pmem_wdata  out  128  pmem write data
pmem_rdata  in  128  pmem read data
pmem_resp  in  1  pmem completion pulse

Behaviour:
Clock and reset:
- One clock (clk).
- Reset is asynchronous and active-low (rst_n).
- Reset clears all entry valid bits, head, tail and count; state = IDLE; every output = 0.
- Reset mid-transaction drops buffered data and the outstanding request; pmem_read/pmem_write deassert immediately (asynchronously).

Storage and matching:
- Circular FIFO of DEPTH entries {valid, tag[11:0] = addr[15:4], data[127:0]}.
- Match = valid entry whose tag equals ev_addr[15:4].
- Invariant: at most one entry matches any tag.

State machine (IDLE, RESP, PMEM_RD, DRAIN). In IDLE, evaluate in this priority order:
1. ev_read and match -> ev_rdata <= entry data; go to RESP.
2. ev_read and no match -> go to PMEM_RD.
3. ev_write and match -> overwrite that entry's data (coalesce; no new entry, FIFO order unchanged); go to RESP.
4. ev_write and count < DEPTH -> push at tail, count+1; go to RESP.
5. ev_write and full -> go to DRAIN; the write is retried in IDLE afterwards.
6. No request and count > 0 -> go to DRAIN (background drain).
7. Otherwise stay in IDLE.

PMEM_RD:
- pmem_read = 1, pmem_addr = {ev_addr[15:4], 4'b0}.
- On pmem_resp: ev_rdata <= pmem_rdata; go to RESP.

DRAIN:
- pmem_write = 1, pmem_addr = {head tag, 4'b0}, pmem_wdata = head data.
- On pmem_resp: pop head (valid = 0, head+1 mod DEPTH, count-1); go to IDLE.
- The head entry stays matchable until popped.
- A drain is never aborted; a request arriving mid-drain waits.

RESP:
- ev_resp = 1 for exactly one cycle; then go to IDLE.
- The arbiter drops its request in the RESP cycle.

Output rules:
- Outside PMEM_RD/DRAIN, pmem_read = pmem_write = 0 and pmem_addr = pmem_wdata = 0.
- ev_rdata is registered and holds its value between responses.

Requests and latency:
- Simultaneous ev_read and ev_write: read is served first; the write is served in a later IDLE visit.
- Latencies: buffered write or read hit = ev_resp 2 cycles after request sampled; read miss = pmem latency + 2.
- Read-after-write to the same line always returns the buffered (newest) data and never stale pmem data.
- Head/tail wrap modulo DEPTH.
- count never exceeds DEPTH and never underflows.

Decomposition:
- Package wb_pkg: ADDR_W, LINE_W, OFFSET_W = 4, TAG_W = ADDR_W - OFFSET_W, wb_state_t enum {IDLE, RESP, PMEM_RD, DRAIN}, wb_entry_t struct {valid, tag, data}.
- One natural sub-module, wb_entry_store, containing:
  - FIFO array, head/tail/count;
  - push, pop and coalesce-write ports;
  - combinational match/hit-index/hit-data outputs, full, empty.
- The top-level holds the FSM and output muxing.

Test Plan:
- Reset, then ev_write addr 0x1230, data A -> ev_resp 2 cycles later, no pmem activity that cycle; next IDLE starts DRAIN with pmem_addr 0x1230, pmem_wdata A; after pmem_resp, count = 0.
- Write 0x1230 = A, then ev_read 0x1238 -> ev_rdata = A from the buffer, pmem_read never asserts.
- With DEPTH=2 full (0x1000, 0x2000) and pmem stalled 5 cycles, ev_write 0x3000 -> DRAIN writes 0x1000 first; ev_resp for 0x3000 arrives only after that pmem_resp and the following IDLE/RESP; final drain order is 0x2000, then 0x3000.
- Write 0x4000 = A, write 0x4004 = B -> single entry holding B, count = 1; drain issues exactly one pmem_write of B.
- ev_read 0x5000 with an empty buffer, pmem returns C after 3 cycles -> pmem_read held 3 cycles with pmem_addr 0x5000; ev_rdata = C with a one-cycle ev_resp.
- Assert rst_n low during DRAIN -> pmem_write drops in the same cycle; after release, count = 0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback buffer: line geometry, FSM states
// and the layout of one buffered line entry.
package wb_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP    = 2'd1,
        PMEM_RD = 2'd2,
        DRAIN   = 2'd3
    } wb_state_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_entry_store.sv
// Circular FIFO of buffered dirty lines with a fully associative tag lookup,
// supporting push at tail, pop at head and in-place coalescing of a hit entry.
module wb_entry_store
    import wb_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [TAG_W-1:0]  push_tag_i,
    input  logic [LINE_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              wr_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [LINE_W-1:0] wr_data_i,
    input  logic [TAG_W-1:0]  lookup_tag_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  hit_idx_o,
    output logic [LINE_W-1:0] hit_data_o,
    output logic [TAG_W-1:0]  head_tag_o,
    output logic [LINE_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    wb_entry_t        ent_q [DEPTH];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i && !full_o;
    assign do_pop      = pop_i && !empty_o;
    assign head_tag_o  = ent_q[head_q].tag;
    assign head_data_o = ent_q[head_q].data;

    // At most one valid entry carries a given tag, so the first match is the only one.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit_o && ent_q[i].valid && (ent_q[i].tag == lookup_tag_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
        hit_data_o = ent_q[hit_idx_o].data;
    end

    always_comb begin
        head_d  = do_pop  ? next_idx(head_q) : head_q;
        tail_d  = do_push ? next_idx(tail_q) : tail_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_i) begin
                ent_q[wr_idx_i].data <= wr_data_i;
            end
            if (do_pop) begin
                ent_q[head_q].valid <= 1'b0;
            end
            if (do_push) begin
                ent_q[tail_q] <= '{valid: 1'b1, tag: push_tag_i, data: push_data_i};
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer between the L1 arbiter and pmem: absorbs dirty lines, serves
// reads from buffered lines or pmem, and drains buffered lines in the background.
module writeback_buffer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_read,
    input  logic              ev_write,
    input  logic [ADDR_W-1:0] ev_addr,
    input  logic [LINE_W-1:0] ev_wdata,
    output logic [LINE_W-1:0] ev_rdata,
    output logic              ev_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import wb_pkg::*;

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_state_t         state_q, state_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic              push, pop, wr;
    logic              hit, full, empty;
    logic [IDX_W-1:0]  hit_idx;
    logic [LINE_W-1:0] hit_data, head_data;
    logic [TAG_W-1:0]  head_tag, ev_tag;
    logic              unused_offset;

    assign ev_tag        = ev_addr[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^ev_addr[OFFSET_W-1:0];

    wb_entry_store #(
        .DEPTH(DEPTH)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_tag_i  (ev_tag),
        .push_data_i (ev_wdata),
        .pop_i       (pop),
        .wr_i        (wr),
        .wr_idx_i    (hit_idx),
        .wr_data_i   (ev_wdata),
        .lookup_tag_i(ev_tag),
        .hit_o       (hit),
        .hit_idx_o   (hit_idx),
        .hit_data_o  (hit_data),
        .head_tag_o  (head_tag),
        .head_data_o (head_data),
        .full_o      (full),
        .empty_o     (empty)
    );

    // Reads win over writes; a write to a full buffer forces one drain and retries.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        push    = 1'b0;
        pop     = 1'b0;
        wr      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ev_read) begin
                    if (hit) begin
                        rdata_d = hit_data;
                        state_d = RESP;
                    end else begin
                        state_d = PMEM_RD;
                    end
                end else if (ev_write) begin
                    if (hit) begin
                        wr      = 1'b1;
                        state_d = RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            RESP: state_d = IDLE;
            PMEM_RD: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        if (state_q == PMEM_RD) begin
            pmem_read = 1'b1;
            pmem_addr = {ev_tag, {OFFSET_W{1'b0}}};
        end else if (state_q == DRAIN) begin
            pmem_write = 1'b1;
            pmem_addr  = {head_tag, {OFFSET_W{1'b0}}};
            pmem_wdata = head_data;
        end
    end

    assign ev_resp  = (state_q == RESP);
    assign ev_rdata = rdata_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: buffered writes, read hits/misses,
// full-buffer stall, coalescing and asynchronous reset during a drain.
module tb_writeback_buffer;

    import wb_pkg::*;

    localparam logic [127:0] DA = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DB = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] DC = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
    localparam logic [127:0] D1 = 128'h1111_0000_1111_0000_1111_0000_1111_0001;
    localparam logic [127:0] D2 = 128'h2222_0000_2222_0000_2222_0000_2222_0002;
    localparam logic [127:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
    localparam logic [127:0] DE = 128'hEEEE_9999_EEEE_9999_EEEE_9999_EEEE_9999;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ev_read = 1'b0;
    logic         ev_write = 1'b0;
    logic [15:0]  ev_addr = '0;
    logic [127:0] ev_wdata = '0;
    logic [127:0] ev_rdata;
    logic         ev_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_addr;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_buffer #(
        .DEPTH (2),
        .ADDR_W(16),
        .LINE_W(128)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ev_read   (ev_read),
        .ev_write  (ev_write),
        .ev_addr   (ev_addr),
        .ev_wdata  (ev_wdata),
        .ev_rdata  (ev_rdata),
        .ev_resp   (ev_resp),
        .pmem_read (pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr (pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp (pmem_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on the first cycle of a DRAIN; holds pmem off for 'stall' cycles, then completes it.
    task automatic drain_one(input string tag, input logic [15:0] addr, input logic [127:0] data,
                             input int stall);
        chk({tag, "_pw"}, 128'(pmem_write), 128'(1'b1));
        chk({tag, "_pa"}, 128'(pmem_addr), 128'(addr));
        chk({tag, "_pd"}, pmem_wdata, data);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_pw"}, 128'(pmem_write), 128'(1'b1));
            chk({tag, "_stall_resp"}, 128'(ev_resp), 128'(1'b0));
        end
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk({tag, "_done_pw"}, 128'(pmem_write), 128'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_resp", 128'(ev_resp), 128'(1'b0));
        chk("rst_pr", 128'(pmem_read), 128'(1'b0));
        chk("rst_pw", 128'(pmem_write), 128'(1'b0));
        chk("rst_pa", 128'(pmem_addr), 128'(16'h0));
        chk("rst_pd", pmem_wdata, 128'h0);
        chk("rst_rd", ev_rdata, 128'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_state", 128'(dut.state_q), 128'(IDLE));
        chk("rst_cnt", 128'(dut.u_store.count_q), 128'(0));

        // Buffered write then background drain
        ev_write = 1'b1; ev_addr = 16'h1230; ev_wdata = DA;
        tick();
        chk("w1_resp", 128'(ev_resp), 128'(1'b1));
        chk("w1_pw", 128'(pmem_write), 128'(1'b0));
        chk("w1_cnt", 128'(dut.u_store.count_q), 128'(1));
        ev_write = 1'b0;
        tick();
        chk("w1_resp_off", 128'(ev_resp), 128'(1'b0));
        tick();
        drain_one("w1_drain", 16'h1230, DA, 1);
        chk("w1_cnt_end", 128'(dut.u_store.count_q), 128'(0));
        tick();
        chk("w1_idle_pw", 128'(pmem_write), 128'(1'b0));

        // Read hit on a buffered line (offset bits ignored)
        ev_write = 1'b1; ev_addr = 16'h1230; ev_wdata = DA;
        tick();
        chk("rh_wresp", 128'(ev_resp), 128'(1'b1));
        ev_write = 1'b0; ev_read = 1'b1; ev_addr = 16'h1238;
        tick();
        chk("rh_pr0", 128'(pmem_read), 128'(1'b0));
        tick();
        chk("rh_resp", 128'(ev_resp), 128'(1'b1));
        chk("rh_data", ev_rdata, DA);
        chk("rh_pr1", 128'(pmem_read), 128'(1'b0));
        ev_read = 1'b0;
        tick();
        tick();
        drain_one("rh_drain", 16'h1230, DA, 0);

        // Full buffer: write stalls behind a forced drain
        ev_write = 1'b1; ev_addr = 16'h1000; ev_wdata = D1;
        tick();
        chk("f_resp1", 128'(ev_resp), 128'(1'b1));
        ev_addr = 16'h2000; ev_wdata = D2;
        tick();
        chk("f_gap", 128'(ev_resp), 128'(1'b0));
        tick();
        chk("f_resp2", 128'(ev_resp), 128'(1'b1));
        chk("f_cnt2", 128'(dut.u_store.count_q), 128'(2));
        ev_addr = 16'h3000; ev_wdata = D3;
        tick();
        tick();
        chk("f_noresp", 128'(ev_resp), 128'(1'b0));
        drain_one("f_drain1", 16'h1000, D1, 4);
        chk("f_after_pop", 128'(ev_resp), 128'(1'b0));
        tick();
        chk("f_resp3", 128'(ev_resp), 128'(1'b1));
        chk("f_cnt3", 128'(dut.u_store.count_q), 128'(2));
        ev_write = 1'b0;
        tick();
        tick();
        drain_one("f_drain2", 16'h2000, D2, 0);
        tick();
        drain_one("f_drain3", 16'h3000, D3, 0);
        chk("f_cnt_end", 128'(dut.u_store.count_q), 128'(0));

        // Coalescing write to the same line
        ev_write = 1'b1; ev_addr = 16'h4000; ev_wdata = DA;
        tick();
        chk("c_resp1", 128'(ev_resp), 128'(1'b1));
        ev_addr = 16'h4004; ev_wdata = DB;
        tick();
        tick();
        chk("c_resp2", 128'(ev_resp), 128'(1'b1));
        chk("c_cnt", 128'(dut.u_store.count_q), 128'(1));
        ev_write = 1'b0;
        tick();
        tick();
        drain_one("c_drain", 16'h4000, DB, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c_no_second_pw", 128'(pmem_write), 128'(1'b0));
        end

        // Read miss served by pmem after 3 cycles
        ev_read = 1'b1; ev_addr = 16'h5000;
        tick();
        chk("m_pr1", 128'(pmem_read), 128'(1'b1));
        chk("m_pa", 128'(pmem_addr), 128'(16'h5000));
        chk("m_pw", 128'(pmem_write), 128'(1'b0));
        tick();
        chk("m_pr2", 128'(pmem_read), 128'(1'b1));
        tick();
        chk("m_pr3", 128'(pmem_read), 128'(1'b1));
        pmem_resp = 1'b1; pmem_rdata = DC;
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        chk("m_resp", 128'(ev_resp), 128'(1'b1));
        chk("m_data", ev_rdata, DC);
        chk("m_pr_off", 128'(pmem_read), 128'(1'b0));
        ev_read = 1'b0;
        tick();
        chk("m_resp_off", 128'(ev_resp), 128'(1'b0));
        chk("m_hold", ev_rdata, DC);

        // Asynchronous reset in the middle of a drain
        ev_write = 1'b1; ev_addr = 16'h6000; ev_wdata = DE;
        tick();
        ev_write = 1'b0;
        tick();
        tick();
        chk("r_pw_before", 128'(pmem_write), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_pw_async", 128'(pmem_write), 128'(1'b0));
        chk("r_pa_async", 128'(pmem_addr), 128'(16'h0));
        chk("r_pd_async", pmem_wdata, 128'h0);
        chk("r_rd_async", ev_rdata, 128'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r_cnt", 128'(dut.u_store.count_q), 128'(0));
        chk("r_state", 128'(dut.state_q), 128'(IDLE));
        chk("r_resp", 128'(ev_resp), 128'(1'b0));
        tick();
        tick();
        chk("r_no_drain", 128'(pmem_write), 128'(1'b0));
        chk("r_no_read", 128'(pmem_read), 128'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
